// File: rtl/mrv_sram_arbiter.sv
// Two-to-one arbiter sharing one SRAM-style port between instruction and data requesters.
// Fixed data priority with a bounded instruction starvation window, or round-robin.
module mrv_sram_arbiter #(
  parameter bit PRIORITY_D   = 1'b1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        i_cen,
  input  logic        i_wen,
  input  logic [3:0]  i_strb,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        i_stall,
  output logic        i_error,
  output logic [31:0] i_rdata,
  input  logic        d_cen,
  input  logic        d_wen,
  input  logic [3:0]  d_strb,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_stall,
  output logic        d_error,
  output logic [31:0] d_rdata,
  output logic        m_cen,
  output logic        m_wen,
  output logic [3:0]  m_strb,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_stall,
  input  logic        m_error,
  input  logic [31:0] m_rdata,
  output logic        m_owner_d
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);

  state_t      state_r;
  state_t      state_next_s;
  state_t      eff_state_s;
  logic        last_d_r;
  logic        eff_last_d_s;
  logic [3:0]  streak_r;
  logic [3:0]  eff_streak_s;
  logic        grant_s;
  logic        sel_d_s;
  logic        complete_s;

  // While reset is asserted the port behaves as if idle with cleared history.
  assign eff_state_s  = g_reset ? IDLE : state_r;
  assign eff_last_d_s = g_reset ? 1'b1 : last_d_r;
  assign eff_streak_s = g_reset ? 4'd0 : streak_r;

  // Owner selection: arbitrate only from IDLE, otherwise keep the current owner.
  always_comb begin
    grant_s = 1'b0;
    sel_d_s = 1'b0;
    case (eff_state_s)
      IDLE: begin
        if (i_cen && d_cen) begin
          grant_s = 1'b1;
          if (PRIORITY_D) begin
            sel_d_s = (eff_streak_s != STARVE_LIM_C);
          end else begin
            sel_d_s = ~eff_last_d_s;
          end
        end else if (d_cen) begin
          grant_s = 1'b1;
          sel_d_s = 1'b1;
        end else if (i_cen) begin
          grant_s = 1'b1;
          sel_d_s = 1'b0;
        end else begin
          grant_s = 1'b0;
          sel_d_s = 1'b0;
        end
      end
      BUSY_I: begin
        grant_s = 1'b1;
        sel_d_s = 1'b0;
      end
      BUSY_D: begin
        grant_s = 1'b1;
        sel_d_s = 1'b1;
      end
      default: begin
        grant_s = 1'b0;
        sel_d_s = 1'b0;
      end
    endcase
  end

  assign complete_s = grant_s & ~m_stall;

  // Request forwarding, stall/error routing and next-state decision.
  always_comb begin
    m_cen        = 1'b0;
    m_wen        = 1'b0;
    m_strb       = 4'd0;
    m_addr       = 32'd0;
    m_wdata      = 32'd0;
    m_owner_d    = 1'b0;
    i_stall      = i_cen;
    d_stall      = d_cen;
    i_error      = 1'b0;
    d_error      = 1'b0;
    state_next_s = IDLE;
    if (grant_s) begin
      m_cen     = 1'b1;
      m_owner_d = sel_d_s;
      if (sel_d_s) begin
        m_wen   = d_wen;
        m_strb  = d_strb;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        d_stall = m_stall;
        d_error = m_error & complete_s;
      end else begin
        m_wen   = i_wen;
        m_strb  = i_strb;
        m_addr  = i_addr;
        m_wdata = i_wdata;
        i_stall = m_stall;
        i_error = m_error & complete_s;
      end
      if (m_stall) begin
        state_next_s = sel_d_s ? BUSY_D : BUSY_I;
      end else begin
        state_next_s = IDLE;
      end
    end else begin
      state_next_s = IDLE;
    end
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // State, last-owner and data-streak registers; the streak counts data wins over a waiting fetch.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_r  <= IDLE;
      last_d_r <= 1'b1;
      streak_r <= 4'd0;
    end else begin
      state_r <= state_next_s;
      if (complete_s) begin
        last_d_r <= sel_d_s;
        if (sel_d_s && i_cen) begin
          streak_r <= (streak_r >= STARVE_LIM_C) ? STARVE_LIM_C : streak_r + 4'd1;
        end else begin
          streak_r <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mrv_sram_arbiter.sv
// Self-checking bench for mrv_sram_arbiter: a priority instance and a round-robin instance
// share stimulus; vector table, directed corner sequences and random traffic against a model.
module tb_mrv_sram_arbiter;

  localparam int LIM = 4;

  logic g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  logic        g_reset;
  logic        i_cen, i_wen, d_cen, d_wen, m_stall, m_error;
  logic [3:0]  i_strb, d_strb;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, m_rdata;

  logic [1:0]  i_stall_v, i_error_v, d_stall_v, d_error_v, m_cen_v, m_wen_v, m_owner_d_v;
  logic [3:0]  m_strb_v [2];
  logic [31:0] i_rdata_v [2];
  logic [31:0] d_rdata_v [2];
  logic [31:0] m_addr_v [2];
  logic [31:0] m_wdata_v [2];

  int checks = 0;
  int errors = 0;

  // index 0: data priority, index 1: round-robin
  mrv_sram_arbiter #(.PRIORITY_D(1'b1), .STARVE_LIMIT(LIM)) u_dut_p (
    .g_clk(g_clk), .g_reset(g_reset),
    .i_cen(i_cen), .i_wen(i_wen), .i_strb(i_strb), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_stall(i_stall_v[0]), .i_error(i_error_v[0]), .i_rdata(i_rdata_v[0]),
    .d_cen(d_cen), .d_wen(d_wen), .d_strb(d_strb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_stall(d_stall_v[0]), .d_error(d_error_v[0]), .d_rdata(d_rdata_v[0]),
    .m_cen(m_cen_v[0]), .m_wen(m_wen_v[0]), .m_strb(m_strb_v[0]), .m_addr(m_addr_v[0]),
    .m_wdata(m_wdata_v[0]), .m_stall(m_stall), .m_error(m_error), .m_rdata(m_rdata),
    .m_owner_d(m_owner_d_v[0])
  );

  mrv_sram_arbiter #(.PRIORITY_D(1'b0), .STARVE_LIMIT(LIM)) u_dut_rr (
    .g_clk(g_clk), .g_reset(g_reset),
    .i_cen(i_cen), .i_wen(i_wen), .i_strb(i_strb), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_stall(i_stall_v[1]), .i_error(i_error_v[1]), .i_rdata(i_rdata_v[1]),
    .d_cen(d_cen), .d_wen(d_wen), .d_strb(d_strb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_stall(d_stall_v[1]), .d_error(d_error_v[1]), .d_rdata(d_rdata_v[1]),
    .m_cen(m_cen_v[1]), .m_wen(m_wen_v[1]), .m_strb(m_strb_v[1]), .m_addr(m_addr_v[1]),
    .m_wdata(m_wdata_v[1]), .m_stall(m_stall), .m_error(m_error), .m_rdata(m_rdata),
    .m_owner_d(m_owner_d_v[1])
  );

  // Reference model: transaction owner in flight (0 none, 1 I, 2 D), last winner, data streak.
  int busy_m [2];
  bit last_d_m [2];
  int streak_m [2];
  int own_m [2];
  bit exp_i_stall [2];
  bit exp_d_stall [2];

  typedef struct {
    logic ic; logic iw; logic [3:0] is4; logic [31:0] ia; logic [31:0] iwd;
    logic dc; logic dw; logic [3:0] ds4; logic [31:0] da; logic [31:0] dwd;
    logic ms; logic me; logic [31:0] mr;
    logic e_cen; logic e_wen; logic [3:0] e_strb; logic [31:0] e_addr; logic [31:0] e_wdata;
    logic e_own; logic e_istall; logic e_dstall; logic e_ierr; logic e_derr;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [138:0] act, input logic [138:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [138:0] dut_bundle(input int c);
    return {m_cen_v[c], m_wen_v[c], m_strb_v[c], m_addr_v[c], m_wdata_v[c], m_owner_d_v[c],
            i_stall_v[c], d_stall_v[c], i_error_v[c], d_error_v[c], i_rdata_v[c], d_rdata_v[c]};
  endfunction

  task automatic model_check();
    for (int c = 0; c < 2; c++) begin
      int own; bit ld; int st;
      logic comp, e_wen;
      logic [3:0] e_strb;
      logic [31:0] e_addr, e_wdata;
      ld = g_reset ? 1'b1 : last_d_m[c];
      st = g_reset ? 0 : streak_m[c];
      if (!g_reset && busy_m[c] != 0) own = busy_m[c];
      else if (i_cen && d_cen) own = (c == 0) ? ((st == LIM) ? 1 : 2) : (ld ? 1 : 2);
      else if (d_cen) own = 2;
      else if (i_cen) own = 1;
      else own = 0;
      own_m[c] = own;
      if (!g_reset && ((busy_m[c] == 1 && !i_cen) || (busy_m[c] == 2 && !d_cen))) begin
        errors++;
        $display("FAIL protocol[%0d]: owner dropped cen while busy", c);
      end
      comp = (own != 0) && !m_stall;
      e_wen = 1'b0; e_strb = 4'd0; e_addr = 32'd0; e_wdata = 32'd0;
      if (own == 1) begin e_wen = i_wen; e_strb = i_strb; e_addr = i_addr; e_wdata = i_wdata; end
      if (own == 2) begin e_wen = d_wen; e_strb = d_strb; e_addr = d_addr; e_wdata = d_wdata; end
      exp_i_stall[c] = (own == 1) ? m_stall : i_cen;
      exp_d_stall[c] = (own == 2) ? m_stall : d_cen;
      chk($sformatf("model[%0d]", c), dut_bundle(c),
          {(own != 0), e_wen, e_strb, e_addr, e_wdata, (own == 2), exp_i_stall[c],
           exp_d_stall[c], (m_error && comp && own == 1), (m_error && comp && own == 2),
           m_rdata, m_rdata});
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < 2; c++) begin
      if (g_reset) begin
        busy_m[c] = 0; last_d_m[c] = 1'b1; streak_m[c] = 0;
      end else if (own_m[c] != 0) begin
        if (!m_stall) begin
          busy_m[c]   = 0;
          last_d_m[c] = (own_m[c] == 2);
          if (own_m[c] == 2 && i_cen) streak_m[c] = (streak_m[c] < LIM) ? streak_m[c] + 1 : LIM;
          else streak_m[c] = 0;
        end else begin
          busy_m[c] = own_m[c];
        end
      end
    end
  endtask

  task automatic step_cycle();
    model_check();
    @(posedge g_clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic a_ic, input logic a_iw, input logic [3:0] a_is,
                       input logic [31:0] a_ia, input logic [31:0] a_iwd,
                       input logic a_dc, input logic a_dw, input logic [3:0] a_ds,
                       input logic [31:0] a_da, input logic [31:0] a_dwd,
                       input logic a_ms, input logic a_me, input logic [31:0] a_mr);
    i_cen = a_ic; i_wen = a_iw; i_strb = a_is; i_addr = a_ia; i_wdata = a_iwd;
    d_cen = a_dc; d_wen = a_dw; d_strb = a_ds; d_addr = a_da; d_wdata = a_dwd;
    m_stall = a_ms; m_error = a_me; m_rdata = a_mr;
  endtask

  task automatic do_reset();
    g_reset = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #3;
    chk("reset_outputs", dut_bundle(0), 139'd0);
    step_cycle();
    g_reset = 1'b0;
  endtask

  initial begin
    int exp_p [6];
    int exp_rr [6];
    exp_p  = '{1, 1, 1, 1, 0, 1};
    exp_rr = '{0, 1, 0, 1, 0, 1};
    for (int c = 0; c < 2; c++) begin
      busy_m[c] = 0; last_d_m[c] = 1'b1; streak_m[c] = 0; own_m[c] = 0;
      exp_i_stall[c] = 1'b0; exp_d_stall[c] = 1'b0;
    end
    // ic iw is ia iwd | dc dw ds da dwd | ms me mr | e_cen e_wen e_strb e_addr e_wdata | own ist dst ierr derr
    tbl[0] = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hA5A5_A5A5,
               1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 4'h0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1234_5678,
               1'b1, 1'b0, 4'h0, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hCAFE_F00D,
               1'b1, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 4'h0, 32'h0000_0200, 32'h0, 1'b1, 1'b1, 4'h3, 32'h0000_0300, 32'h1111_2222, 1'b0, 1'b0, 32'h0,
               1'b1, 1'b1, 4'h3, 32'h0000_0300, 32'h1111_2222, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 4'h0, 32'h0000_0400, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h55AA_55AA,
               1'b1, 1'b0, 4'h0, 32'h0000_0400, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 4'hC, 32'h0000_0500, 32'h7777_8888, 1'b1, 1'b0, 4'h0, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 32'h0,
               1'b1, 1'b0, 4'h0, 32'h0000_0600, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(tbl[k].ic, tbl[k].iw, tbl[k].is4, tbl[k].ia, tbl[k].iwd, tbl[k].dc, tbl[k].dw,
            tbl[k].ds4, tbl[k].da, tbl[k].dwd, tbl[k].ms, tbl[k].me, tbl[k].mr);
      #3;
      chk($sformatf("vec%0d", k),
          139'({m_cen_v[0], m_wen_v[0], m_strb_v[0], m_addr_v[0], m_wdata_v[0], m_owner_d_v[0],
                i_stall_v[0], d_stall_v[0], i_error_v[0], d_error_v[0], i_rdata_v[0]}),
          139'({tbl[k].e_cen, tbl[k].e_wen, tbl[k].e_strb, tbl[k].e_addr, tbl[k].e_wdata, tbl[k].e_own,
                tbl[k].e_istall, tbl[k].e_dstall, tbl[k].e_ierr, tbl[k].e_derr, tbl[k].mr}));
      step_cycle();
    end

    // Stalled data transaction holds the port for four cycles, fetch follows the next cycle.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_2000, 32'h0,
            (k < 3), 1'b0, 32'h0);
      #3;
      chk($sformatf("busy_d_addr%0d", k), 139'(m_addr_v[0]), 139'(32'h0000_2000));
      chk($sformatf("busy_d_istall%0d", k), 139'(i_stall_v[0]), 139'(1'b1));
      chk($sformatf("busy_d_dstall%0d", k), 139'(d_stall_v[0]), 139'((k < 3) ? 1'b1 : 1'b0));
      step_cycle();
    end
    drive(1'b1, 1'b0, 4'h0, 32'h0000_1000, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    #3;
    chk("after_d_addr", 139'(m_addr_v[0]), 139'(32'h0000_1000));
    chk("after_d_owner", 139'(m_owner_d_v[0]), 139'(1'b0));
    chk("after_d_istall", 139'(i_stall_v[0]), 139'(1'b0));
    step_cycle();

    // Continuous contention: starvation bound on the priority side, alternation on round-robin.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0,
            1'b0, 1'b0, 32'h0);
      #3;
      chk($sformatf("starve_owner%0d", k), 139'(m_owner_d_v[0]), 139'(exp_p[k]));
      chk($sformatf("rr_owner%0d", k), 139'(m_owner_d_v[1]), 139'(exp_rr[k]));
      step_cycle();
    end

    // Reset in the middle of a stalled fetch.
    do_reset();
    drive(1'b1, 1'b0, 4'h0, 32'h0000_0030, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    #3;
    step_cycle();
    g_reset = 1'b1;
    #3;
    chk("rst_busy_owner", 139'(m_owner_d_v[0]), 139'(1'b0));
    chk("rst_busy_istall", 139'(i_stall_v[0]), 139'(1'b1));
    chk("rst_busy_dstall", 139'(d_stall_v[0]), 139'(1'b0));
    step_cycle();
    g_reset = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 32'h0);
    #3;
    chk("post_rst_owner", 139'(m_owner_d_v[0]), 139'(1'b1));
    chk("post_rst_addr", 139'(m_addr_v[0]), 139'(32'h0000_0040));
    chk("post_rst_istall", 139'(i_stall_v[0]), 139'(1'b0));
    chk("post_rst_dstall", 139'(d_stall_v[0]), 139'(1'b0));
    step_cycle();

    // Random protocol-legal traffic: a stalled requester holds its request unchanged.
    for (int n = 0; n < 400; n++) begin
      logic hold_i, hold_d;
      hold_i = i_cen && (exp_i_stall[0] || exp_i_stall[1]);
      hold_d = d_cen && (exp_d_stall[0] || exp_d_stall[1]);
      if (!hold_i) begin
        i_cen = ($urandom_range(0, 3) != 0); i_wen = 1'($urandom); i_strb = 4'($urandom);
        i_addr = $urandom; i_wdata = $urandom;
      end
      if (!hold_d) begin
        d_cen = ($urandom_range(0, 3) != 0); d_wen = 1'($urandom); d_strb = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      m_stall = ($urandom_range(0, 2) == 0);
      m_error = 1'($urandom);
      m_rdata = $urandom;
      g_reset = ($urandom_range(0, 59) == 0);
      #3;
      step_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
